// File: rtl/wt_dcache_ship_predictor.sv
// wt_dcache_ship_predictor
// Signature-indexed table of saturating re-reference counters (SHiP-style).
// A hit increments the counter of the line's signature; an eviction of a line
// that was never re-referenced decrements it. Lookups return the counter one
// cycle later. A flush sweeps CtrInit into FlushLanes entries per cycle.
// Optional build macro: WT_DCACHE_SHIP_FWD_EN -- when defined, a lookup in the
// same cycle as an update to the same signature sees the post-update value;
// when undefined it sees the pre-update value.
module wt_dcache_ship_predictor #(
  parameter int unsigned SigWidth   = 14,
  parameter int unsigned CtrWidth   = 2,
  parameter int unsigned CtrInit    = (2**CtrWidth) - 1,
  parameter int unsigned FlushLanes = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                lkup_req_i,
  input  logic [SigWidth-1:0] lkup_sig_i,
  output logic                lkup_vld_o,
  output logic [CtrWidth-1:0] lkup_ctr_o,
  output logic                lkup_reuse_o,
  input  logic                hit_i,
  input  logic [SigWidth-1:0] hit_sig_i,
  input  logic                evict_i,
  input  logic                evict_reused_i,
  input  logic [SigWidth-1:0] evict_sig_i,
  output logic                busy_o
);

  localparam int unsigned        Depth   = 2**SigWidth;
  localparam logic [SigWidth-1:0] PtrStep = SigWidth'(FlushLanes);
  localparam logic [SigWidth-1:0] PtrLast = SigWidth'(Depth - FlushLanes);
  localparam logic [CtrWidth-1:0] CtrMax  = {CtrWidth{1'b1}};
  localparam logic [CtrWidth-1:0] CtrRst  = CtrWidth'(CtrInit);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Apply one cycle of up/down requests to a counter; both together cancel.
  function automatic logic [CtrWidth-1:0] f_update(input logic [CtrWidth-1:0] cur,
                                                   input logic up,
                                                   input logic dn);
    logic [CtrWidth-1:0] res;
    res = cur;
    if (up && !dn) begin
      if (cur != CtrMax) res = cur + CtrWidth'(1);
    end else if (dn && !up) begin
      if (cur != {CtrWidth{1'b0}}) res = cur - CtrWidth'(1);
    end
    return res;
  endfunction

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SigWidth-1:0] r_ptr;
  logic                r_busy;
  logic                r_lkup_vld;
  logic [CtrWidth-1:0] r_lkup_ctr;
  logic                r_lkup_reuse;
  logic [CtrWidth-1:0] r_table [Depth];

  logic                w_last;
  logic                w_sweep_en;
  logic                w_upd_en;
  logic                w_busy_nxt;
  logic                w_dec;
  logic [CtrWidth-1:0] w_hit_val;
  logic [CtrWidth-1:0] w_evict_val;
  logic [CtrWidth-1:0] w_rd_val;
  logic [CtrWidth-1:0] w_fwd_val;
  logic [CtrWidth-1:0] w_lkup_val;

  assign w_last = (r_ptr == PtrLast);
  assign w_dec  = evict_i && !evict_reused_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: a flush request always (re)enters the sweep.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = flush_i ? FLUSH : IDLE;
      FLUSH:   w_state_nxt = (flush_i || !w_last) ? FLUSH : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: sweep enable, update gating and next busy flag.
  always_comb begin
    w_sweep_en = 1'b0;
    w_upd_en   = 1'b0;
    w_busy_nxt = (w_state_nxt == FLUSH);
    case (r_state)
      IDLE: begin
        w_sweep_en = 1'b0;
        w_upd_en   = !flush_i;
      end
      FLUSH: begin
        w_sweep_en = 1'b1;
        w_upd_en   = 1'b0;
      end
      default: begin
        w_sweep_en = 1'b0;
        w_upd_en   = 1'b0;
      end
    endcase
  end

  // Sweep pointer: restarts on flush, steps by the lane count, wraps at the end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= {SigWidth{1'b0}};
    end else if (flush_i || (w_sweep_en && w_last)) begin
      r_ptr <= {SigWidth{1'b0}};
    end else if (w_sweep_en) begin
      r_ptr <= r_ptr + PtrStep;
    end
  end

  // Post-update values for the hit and eviction targets; same-sig pairs cancel.
  always_comb begin
    w_hit_val   = f_update(r_table[hit_sig_i], 1'b1,
                           w_dec && (evict_sig_i == hit_sig_i));
    w_evict_val = f_update(r_table[evict_sig_i],
                           hit_i && (hit_sig_i == evict_sig_i), 1'b1);
  end

  // Counter table: reset/flush to CtrInit, otherwise apply hit and eviction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) r_table[i] <= CtrRst;
    end else if (w_sweep_en) begin
      for (int l = 0; l < FlushLanes; l++) r_table[r_ptr + SigWidth'(l)] <= CtrRst;
    end else if (w_upd_en) begin
      if (hit_i) r_table[hit_sig_i]   <= w_hit_val;
      if (w_dec) r_table[evict_sig_i] <= w_evict_val;
    end
  end

  // Lookup read path, with optional same-cycle update forwarding.
  always_comb begin
    w_rd_val = r_table[lkup_sig_i];
`ifdef WT_DCACHE_SHIP_FWD_EN
    w_fwd_val = f_update(w_rd_val,
                         w_upd_en && hit_i && (hit_sig_i == lkup_sig_i),
                         w_upd_en && w_dec && (evict_sig_i == lkup_sig_i));
`else
    w_fwd_val = w_rd_val;
`endif
    if (w_sweep_en) w_lkup_val = CtrRst;
    else            w_lkup_val = w_fwd_val;
  end

  // Registered lookup response and busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lkup_vld   <= 1'b0;
      r_lkup_ctr   <= {CtrWidth{1'b0}};
      r_lkup_reuse <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_lkup_vld <= lkup_req_i;
      r_busy     <= w_busy_nxt;
      if (lkup_req_i) begin
        r_lkup_ctr   <= w_lkup_val;
        r_lkup_reuse <= (w_lkup_val != {CtrWidth{1'b0}});
      end
    end
  end

  assign lkup_vld_o   = r_lkup_vld;
  assign lkup_ctr_o   = r_lkup_ctr;
  assign lkup_reuse_o = r_lkup_reuse;
  assign busy_o       = r_busy;

endmodule
